tgbase64_bitpacker: RTL and testbench
=====================================

Name: tgbase64_bitpacker

Overview:
- Downstream stage of the per-character ASCII-to-tgBASE converter.
- Consumes a serial stream of 6-bit tgBASE symbols and packs them MSB-first into 8-bit bytes: 4 symbols become 3 bytes.
- Partial groups are zero-padded on flush. A flush is raised either by an explicit request or automatically after MAX_SYMS symbols (one full 146-character message).
- Feeds the byte-wide storage/transmit path through a valid/ready handshake.

Parameters:
- MAX_SYMS, 146, symbols per message; an automatic flush follows the MAX_SYMS-th accepted symbol.
- CNT_W, 8, width of sym_cnt; must satisfy 2^CNT_W > MAX_SYMS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- sym_in  input  6  tgBASE symbol, 0..63.
- sym_valid  input  1  sym_in is valid.
- sym_ready  output  1  packer accepts sym_in this cycle.
- flush  input  1  end-of-message request (single-cycle pulse).
- byte_out  output  8  packed byte.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  downstream accepts byte_out.
- byte_last  output  1  byte_out is the final byte of the message.
- done  output  1  one-cycle pulse when the message is fully drained.
- sym_cnt  output  CNT_W  symbols accepted in the current message.

Behaviour:
- Reset (async, rst=1):
  - state=RUN; acc=0; nbits=0; sym_cnt=0.
  - byte_valid=0, byte_out=0, byte_last=0, done=0, sym_ready=0 while rst is high.
- Storage:
  - acc is 14 bits; nbits is 0..13.
  - A push appends sym_in below the current bits: acc holds the oldest bit at position nbits-1.
  - A pop takes the top 8 valid bits (acc[nbits-1:nbits-8]) and does nbits-=8.
- Output register:
  - byte_out/byte_valid are registered.
  - While byte_valid=1 and byte_ready=0, byte_out is held stable.
  - A pop loads the output register when (byte_valid=0 or byte_ready=1) and nbits>=8.
  - byte_valid drops the cycle after an accepted byte unless a new pop loads.
- Input handshake:
  - sym_ready = (state==RUN) && (nbits<8).
  - A push occurs on sym_valid && sym_ready.
  - Push and pop are mutually exclusive by construction, so steady-state throughput is 4 symbols per 7 cycles with byte_ready=1.
  - The nbits sequence for one group is 0,6,12,4,10,2,8,0.
- Counting:
  - sym_cnt increments per push.
  - A push that makes sym_cnt==MAX_SYMS forces entry to FLUSH next cycle, as if flush were asserted.
- States:
  - RUN: accept symbols and pop full bytes.
    - flush=1 -> FLUSH at the next edge.
    - If flush and a push occur in the same cycle, the symbol is included in the message.
    - flush while already in FLUSH or DONE is ignored.
  - FLUSH: sym_ready=0; pops continue while nbits>=8.
    - When 0<nbits<8 and the output register is free, load {acc top nbits, (8-nbits) zeros} and set nbits=0.
    - Leave for DONE when nbits==0 and (byte_valid=0, or byte_valid && byte_ready).
  - DONE: done=1 for exactly one cycle; acc, nbits and sym_cnt are cleared; next state is RUN.
- byte_last = byte_valid && state==FLUSH && nbits==0.
  - It also covers a byte already held in the output register when flush arrives with nbits==0.
- Empty flush (nbits==0, byte_valid=0):
  - FLUSH lasts one cycle, then DONE.
  - No byte is emitted and byte_last never asserts.
- Output bytes per message = ceil(6*N/8) for N symbols.
- Reset mid-message or mid-flush: everything is discarded immediately, including a pending byte; byte_valid goes low asynchronously.

Test Plan:
- Group packing: push 0x3F,0x00,0x2A,0x15, byte_ready=1 -> bytes 0xFC,0x0A,0x95; byte_last=0 on all; sym_ready and byte_valid follow the nbits sequence 0,6,12,4,10,2,8,0.
- Padded flush: push 0x01,0x02, then pulse flush -> 0x04, then 0x20 with byte_last=1; done pulses 1 cycle after the 0x20 handshake; sym_cnt returns to 0.
- Auto flush: push 146 symbols of 0x3F, no flush pulse -> 110 bytes; bytes 1..109 are 0xFF; byte 110 is 0xF0 with byte_last=1; then done; sym_ready=0 from cycle after symbol 146 until after done.
- Backpressure: byte_ready=0 for 10 cycles with a byte pending -> byte_out stable, byte_valid=1, sym_ready=0 once nbits>=8; the packed sequence matches the unstalled run.
- Empty flush and flush-with-push:
  - flush at nbits=0 with no pending byte -> no byte_valid; done 2 cycles later.
  - flush coincident with an accepted symbol 0x3F -> 0xFC with byte_last=1.
- Reset mid-flush: assert rst while byte_valid=1 in FLUSH -> byte_valid=0 asynchronously; after release, pushing 0x3F,0x00,0x2A,0x15 yields 0xFC,0x0A,0x95 with no stale bytes.

Source files
------------

// File: rtl/tgbase64_bitpacker.sv
// ---------------------------------------------------------------------------
// tgbase64_bitpacker
//
// Packs a serial stream of 6-bit tgBASE symbols MSB-first into 8-bit bytes
// (4 symbols -> 3 bytes). A message ends on an explicit flush pulse or
// automatically after MAX_SYMS accepted symbols; any partial byte left over
// is zero-padded on the right. Bytes leave through a valid/ready handshake
// with a registered output stage.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   sym_in      6-bit tgBASE symbol (0..63)
//   sym_valid   sym_in is valid
//   sym_ready   packer accepts sym_in this cycle
//   flush       end-of-message request (single-cycle pulse)
//   byte_out    packed byte (registered)
//   byte_valid  byte_out is valid (registered)
//   byte_ready  downstream accepts byte_out
//   byte_last   byte_out is the final byte of the message
//   done        one-cycle pulse once the message is fully drained
//   sym_cnt     symbols accepted in the current message
// ---------------------------------------------------------------------------
module tgbase64_bitpacker #(
   parameter int MAX_SYMS = 146,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       sym_in,
   input  logic             sym_valid,
   output logic             sym_ready,
   input  logic             flush,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             byte_last,
   output logic             done,
   output logic [CNT_W-1:0] sym_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Count value seen on the cycle that accepts the final symbol of a message.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_SYMS - 1);

   state_t      state;
   logic [13:0] acc;     // bit accumulator, oldest valid bit at [nbits-1]
   logic [3:0]  nbits;   // number of valid bits in acc, 0..13

   logic        out_free;
   logic        push;
   logic        pop;
   logic        pad;
   logic        last_push;
   logic [13:0] pop_shift;
   logic [13:0] pad_shift;
   logic [7:0]  pop_byte;
   logic [7:0]  pad_byte;

   // NOTE: always_comb assigns every output before any condition so no latch is inferred.
   always_comb begin
      out_free  = !byte_valid || byte_ready;
      // Symbols are only taken while fewer than 8 bits are buffered, which
      // guarantees room for 6 more bits and keeps push and pop exclusive.
      sym_ready = !rst && (state == ST_RUN) && (nbits < 4'd8);
      push      = sym_valid && sym_ready;
      last_push = push && (sym_cnt == LAST_CNT);
      pop       = (state != ST_DONE) && out_free && (nbits >= 4'd8);
      pad       = (state == ST_FLUSH) && out_free && (nbits != 4'd0) && (nbits < 4'd8);

      // Top 8 valid bits: acc[nbits-1 -: 8]; only meaningful when nbits>=8.
      pop_shift = acc >> (nbits - 4'd8);
      pop_byte  = pop_shift[7:0];

      // Remaining nbits (<8) moved to the top of the byte, zeros below; the
      // stale bits above nbits fall off the top of the 8-bit slice.
      pad_shift = acc << (4'd8 - nbits);
      pad_byte  = pad_shift[7:0];

      // A byte is last once nothing is left to pack behind it in this message.
      byte_last = byte_valid && (state == ST_FLUSH) && (nbits == 4'd0);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         acc        <= '0;
         nbits      <= '0;
         sym_cnt    <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;

         // Output register: load on pop or pad, otherwise release on accept.
         if (pop) begin
            byte_out   <= pop_byte;
            byte_valid <= 1'b1;
         end else if (pad) begin
            byte_out   <= pad_byte;
            byte_valid <= 1'b1;
         end else if (byte_ready) begin
            byte_valid <= 1'b0;
         end

         case (state)
            ST_RUN: begin
               if (push) begin
                  acc     <= {acc[7:0], sym_in};
                  nbits   <= nbits + 4'd6;
                  sym_cnt <= sym_cnt + 1'b1;
               end else if (pop) begin
                  nbits <= nbits - 4'd8;
               end
               // A symbol accepted together with flush still belongs to
               // this message; the MAX_SYMS-th symbol acts as a flush.
               if (flush || last_push) begin
                  state <= ST_FLUSH;
               end
            end

            ST_FLUSH: begin
               if (pop) begin
                  nbits <= nbits - 4'd8;
               end else if (pad) begin
                  nbits <= 4'd0;
               end
               // Drained once no bits remain and the final byte is gone or
               // leaving on this edge.
               if ((nbits == 4'd0) && out_free) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end

            ST_DONE: begin
               acc     <= '0;
               nbits   <= '0;
               sym_cnt <= '0;
               state   <= ST_RUN;
            end

            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tgbase64_bitpacker.sv
// ---------------------------------------------------------------------------
// tb_tgbase64_bitpacker
//
// Directed scenarios plus randomized traffic for tgbase64_bitpacker. A
// message-level reference model turns every accepted symbol into a bit
// queue, cuts bytes from it, pads the tail on flush and marks the final
// byte; a negedge monitor compares each handshaked byte against it.
// ---------------------------------------------------------------------------
module tb_tgbase64_bitpacker;

   localparam int MAX_SYMS = 146;
   localparam int CNT_W    = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [5:0]       sym_in;
   logic             sym_valid;
   logic             sym_ready;
   logic             flush;
   logic [7:0]       byte_out;
   logic             byte_valid;
   logic             byte_ready;
   logic             byte_last;
   logic             done;
   logic [CNT_W-1:0] sym_cnt;

   tgbase64_bitpacker #(.MAX_SYMS(MAX_SYMS), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sym_in     (sym_in),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .flush      (flush),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last),
      .done       (done),
      .sym_cnt    (sym_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;
   int n_bytes  = 0;
   int n_done   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] b;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   bit   bits_q[$];
   bit   flushing  = 1'b0;
   int   cnt_model = 0;
   exp_t mon_e;

   task automatic model_push(input logic [5:0] s);
      exp_t e;
      for (int i = 5; i >= 0; i--) bits_q.push_back(s[i]);
      while (bits_q.size() >= 8) begin
         e.b = 8'h00;
         for (int i = 0; i < 8; i++) e.b = {e.b[6:0], bits_q.pop_front()};
         e.last = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic model_close();
      exp_t e;
      if (bits_q.size() > 0) begin
         e.b = 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (bits_q.size() > 0) e.b = {e.b[6:0], bits_q.pop_front()};
            else                   e.b = {e.b[6:0], 1'b0};
         end
         e.last = 1'b1;
         exp_q.push_back(e);
      end else if (exp_q.size() > 0) begin
         exp_q[exp_q.size()-1].last = 1'b1;
      end
   endtask

   // Monitor: sampled on the falling edge, when inputs and outputs are stable
   // for the handshakes that complete on the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         bits_q.delete();
         flushing  = 1'b0;
         cnt_model = 0;
      end else begin
         check("sym_cnt", 32'(sym_cnt), cnt_model);
         if (flushing) check("sym_ready_in_flush", sym_ready, 1'b0);
         if (byte_valid && byte_ready) begin
            n_bytes++;
            check("byte_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("byte_out", byte_out, mon_e.b);
               check("byte_last", byte_last, mon_e.last);
            end
         end
         if (sym_valid && sym_ready) begin
            model_push(sym_in);
            cnt_model++;
         end
         if (!flushing && (flush || cnt_model == MAX_SYMS)) begin
            model_close();
            flushing = 1'b1;
         end
         if (done) begin
            n_done++;
            check("done_after_flush", flushing, 1'b1);
            check("drained_at_done", exp_q.size(), 0);
            flushing  = 1'b0;
            cnt_model = 0;
         end
      end
   end

   // ---------------- driver helpers ----------------
   logic [5:0] tx_q[$];
   int         br_mode   = 0;     // 0: ready=1, 1: random, 2: ready=0
   bit         rand_mode = 1'b0;  // random gaps and stray flush pulses

   task automatic drive_br();
      case (br_mode)
         0:       byte_ready = 1'b1;
         1:       byte_ready = ($urandom % 3) != 0;
         default: byte_ready = 1'b0;
      endcase
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      drive_br();
   endtask

   task automatic send_all(input int budget);
      int t;
      bit taken;
      t = 0;
      while (tx_q.size() > 0 && t < budget) begin
         sym_in    = tx_q[0];
         sym_valid = rand_mode ? (($urandom % 4) != 0) : 1'b1;
         flush     = rand_mode && (($urandom % 32) == 0);
         @(negedge clk);
         taken = sym_valid && sym_ready;
         next_cycle();
         flush = 1'b0;
         if (taken) void'(tx_q.pop_front());
         t++;
      end
      sym_valid = 1'b0;
      flush     = 1'b0;
      check("send_budget_left", tx_q.size(), 0);
      tx_q.delete();
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < budget && !seen; t++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         if (!seen) next_cycle();
      end
      check("done_seen", seen, 1'b1);
      next_cycle();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [5:0] grp [4];
   logic [3:0] rdy_pat [8];
   logic [7:0] held;
   bit         held_seen;
   int         held_cycles;
   int         idx;
   int         snap_bytes;
   int         snap_done;
   int         nsym;

   initial begin
      rst        = 1'b1;
      sym_in     = 6'd0;
      sym_valid  = 1'b0;
      flush      = 1'b0;
      byte_ready = 1'b1;
      grp        = '{6'h3F, 6'h00, 6'h2A, 6'h15};

      // Reset state while rst is held high.
      @(posedge clk);
      #1;
      check("rst_byte_valid", byte_valid, 1'b0);
      check("rst_byte_out", byte_out, 8'h00);
      check("rst_byte_last", byte_last, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sym_ready", sym_ready, 1'b0);
      check("rst_sym_cnt", 32'(sym_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Group packing: nbits 0,6,12,4,10,2,8,0.
      // sym_ready 1,1,0,1,0,1,0,1 ; byte_valid 0,0,0,1,0,1,0,1.
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         sym_valid = (idx < 4);
         if (idx < 4) sym_in = grp[idx];
         @(negedge clk);
         check("grp_sym_ready", sym_ready, (c == 0 || c == 1 || c == 3 || c == 5 || c == 7));
         check("grp_byte_valid", byte_valid, (c == 3 || c == 5 || c == 7));
         if (sym_valid && sym_ready) idx++;
         next_cycle();
      end
      sym_valid = 1'b0;
      check("grp_all_pushed", idx, 4);

      // Empty flush: nbits=0, nothing pending -> no byte, done two cycles later.
      snap_bytes = n_bytes;
      flush = 1'b1;
      @(negedge clk);
      check("eflush_c0_done", done, 1'b0);
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      check("eflush_c1_done", done, 1'b0);
      check("eflush_c1_valid", byte_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      check("eflush_c2_done", done, 1'b1);
      check("eflush_c2_valid", byte_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      check("eflush_done_one_cycle", done, 1'b0);
      check("eflush_no_bytes", n_bytes - snap_bytes, 0);
      next_cycle();

      // Padded flush: 0x01,0x02 -> 0x04, 0x20(last).
      snap_bytes = n_bytes;
      tx_q = '{6'h01, 6'h02};
      send_all(50);
      pulse_flush();
      wait_done(50);
      @(negedge clk);
      check("pad_sym_cnt_cleared", 32'(sym_cnt), 0);
      check("pad_byte_count", n_bytes - snap_bytes, 2);
      next_cycle();

      // Auto flush after MAX_SYMS symbols of 0x3F.
      snap_bytes = n_bytes;
      snap_done  = n_done;
      for (int i = 0; i < MAX_SYMS; i++) tx_q.push_back(6'h3F);
      send_all(1000);
      wait_done(100);
      check("auto_byte_count", n_bytes - snap_bytes, (MAX_SYMS * 6 + 7) / 8);
      check("auto_done_count", n_done - snap_done, 1);

      // Backpressure: hold byte_ready low while a byte is pending.
      for (int i = 0; i < 6; i++) tx_q.push_back(6'($urandom_range(0, 63)));
      br_mode     = 2;
      byte_ready  = 1'b0;
      held_seen   = 1'b0;
      held_cycles = 0;
      held        = 8'h00;
      for (int c = 0; c < 14; c++) begin
         sym_valid = (tx_q.size() > 0);
         if (tx_q.size() > 0) sym_in = tx_q[0];
         @(negedge clk);
         if (held_seen) begin
            check("bp_valid_held", byte_valid, 1'b1);
            check("bp_out_stable", byte_out, held);
            held_cycles++;
         end else if (byte_valid) begin
            held      = byte_out;
            held_seen = 1'b1;
         end
         if (sym_valid && sym_ready) void'(tx_q.pop_front());
         next_cycle();
      end
      sym_valid = 1'b0;
      @(negedge clk);
      check("bp_sym_ready_low", sym_ready, 1'b0);
      check("bp_held_cycles", (held_cycles >= 10), 1'b1);
      br_mode = 0;
      next_cycle();
      send_all(100);
      pulse_flush();
      wait_done(100);

      // Flush coincident with an accepted symbol: 0x3F -> 0xFC(last).
      snap_bytes = n_bytes;
      sym_valid  = 1'b1;
      sym_in     = 6'h3F;
      flush      = 1'b1;
      @(negedge clk);
      check("fpush_sym_ready", sym_ready, 1'b1);
      next_cycle();
      sym_valid = 1'b0;
      flush     = 1'b0;
      wait_done(20);
      check("fpush_byte_count", n_bytes - snap_bytes, 1);

      // Reset in the middle of a flush with a byte pending.
      br_mode    = 2;
      byte_ready = 1'b0;
      tx_q = '{6'h01, 6'h02};
      send_all(20);
      pulse_flush();
      check("rstf_pending_before", byte_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check("rstf_valid_async", byte_valid, 1'b0);
      check("rstf_last_async", byte_last, 1'b0);
      check("rstf_sym_ready", sym_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      br_mode = 0;
      drive_br();
      snap_bytes = n_bytes;
      tx_q = '{6'h3F, 6'h00, 6'h2A, 6'h15};
      send_all(50);
      pulse_flush();
      wait_done(50);
      check("rstf_byte_count", n_bytes - snap_bytes, 3);

      // Randomized traffic with backpressure, gaps and stray flushes.
      br_mode   = 1;
      rand_mode = 1'b1;
      for (int m = 0; m < 8; m++) begin
         nsym = (m == 3) ? (MAX_SYMS + 4) : int'($urandom_range(1, 24));
         for (int i = 0; i < nsym; i++) tx_q.push_back(6'($urandom_range(0, 63)));
         send_all(4000);
         pulse_flush();
         wait_done(400);
      end
      rand_mode = 1'b0;
      br_mode   = 0;
      repeat (20) next_cycle();
      check("final_queue_empty", exp_q.size(), 0);
      check("final_not_flushing", flushing, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
